axil_command_master: RTL

AXIL_COMMAND_MASTER -- requirements
Module: axil_command_master

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/axi_lite_if.sv | 57 +++++
 rtl/axil_command_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response encodings, default protection bits
// and the state encoding of the command-to-AXI-lite bridge FSM.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_RESP,
    READ_ADDR,
    READ_DATA,
    RESPOND
  } cmd_state_e;

  // Unprivileged, secure, data access on every request.
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle with the five channels; master and slave views.
interface axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/axil_command_master.sv
// Turns a simple valid/ready command stream into single AXI-lite read or
// write transactions, one outstanding at a time, and returns the slave's
// response on a valid/ready response stream.
module axil_command_master #(
  parameter int                      ADDR_WIDTH    = 32,
  parameter int                      DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH/8-1:0] WSTRB_DEFAULT = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  busy,
  axi_lite.master               axi_out
);

  import axi_lite_pkg::*;

  cmd_state_e            state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  arvalid_reg;
  logic                  bready_reg;
  logic                  rready_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [1:0]            rsp_resp_reg;
  logic                  rsp_write_reg;

  // A write channel counts as done once its handshake is in the past or
  // happening this cycle; AW and W may finish in either order.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_reg || axi_out.awready;
  assign w_done  = !wvalid_reg  || axi_out.wready;

  // Accept only from IDLE, and never while reset is held.
  assign cmd_ready = (state_reg == IDLE) && !reset;
  assign busy      = (state_reg != IDLE);

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign rsp_write = rsp_write_reg;

  assign axi_out.awvalid = awvalid_reg;
  assign axi_out.awaddr  = addr_reg;
  assign axi_out.awprot  = AXI_PROT_DEFAULT;
  assign axi_out.wvalid  = wvalid_reg;
  assign axi_out.wdata   = data_reg;
  assign axi_out.wstrb   = WSTRB_DEFAULT;
  assign axi_out.bready  = bready_reg;
  assign axi_out.arvalid = arvalid_reg;
  assign axi_out.araddr  = addr_reg;
  assign axi_out.arprot  = AXI_PROT_DEFAULT;
  assign axi_out.rready  = rready_reg;

  // Transaction FSM; every handshake signal is a register set on entry to
  // the state that owns it and cleared on its own handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_resp_reg  <= 2'b00;
      rsp_write_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            addr_reg      <= cmd_addr;
            data_reg      <= cmd_data;
            rsp_write_reg <= cmd_write;
            if (cmd_write) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WRITE;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= READ_ADDR;
            end
          end
        end
        WRITE: begin
          if (awvalid_reg && axi_out.awready) awvalid_reg <= 1'b0;
          if (wvalid_reg && axi_out.wready)   wvalid_reg  <= 1'b0;
          if (aw_done && w_done) begin
            bready_reg <= 1'b1;
            state_reg  <= WRITE_RESP;
          end
        end
        WRITE_RESP: begin
          if (axi_out.bvalid) begin
            bready_reg    <= 1'b0;
            rsp_resp_reg  <= axi_out.bresp;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESPOND;
          end
        end
        READ_ADDR: begin
          if (axi_out.arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (axi_out.rvalid) begin
            rready_reg    <= 1'b0;
            rsp_resp_reg  <= axi_out.rresp;
            rsp_data_reg  <= axi_out.rdata;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
